// File: rtl/kmeans_centroid_update_k2_d2_pkg.sv
// Shared definitions for the two-centroid, two-dimension k-means update block.
package kmeans_centroid_update_k2_d2_pkg;

    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_COUNT_W = 16;

    typedef enum logic [1:0] {
        ACCUM,
        DIVIDE,
        COMMIT
    } state_t;

endpackage

// File: rtl/kmeans_centroid_update_k2_d2_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// o_done marks the final step; o_quotient is valid in that same cycle.
module kmeans_serial_divider #(
    parameter int unsigned DIVIDEND_W = 32,
    parameter int unsigned DIVISOR_W  = 16,
    parameter int unsigned QUOTIENT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [QUOTIENT_W-1:0] o_quotient
);

    localparam int unsigned STEP_W = $clog2(DIVIDEND_W) + 1;

    logic                  r_busy;
    logic [STEP_W-1:0]     r_step;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [DIVIDEND_W-1:0] r_quo;

    logic                  w_active;
    logic [STEP_W-1:0]     w_step;
    logic [DIVISOR_W-1:0]  w_rem_src;
    logic [DIVISOR_W-1:0]  w_div_src;
    logic [DIVIDEND_W-1:0] w_quo_src;
    logic [DIVISOR_W:0]    w_trial;
    logic                  w_fits;
    logic [DIVISOR_W-1:0]  w_rem_next;
    logic [DIVIDEND_W-1:0] w_quo_next;

    // The start cycle already performs the first step, so a divide costs exactly DIVIDEND_W cycles.
    assign w_active   = i_start | r_busy;
    assign w_step     = i_start ? '0 : r_step;
    assign w_rem_src  = i_start ? '0 : r_rem;
    assign w_div_src  = i_start ? i_divisor : r_divisor;
    assign w_quo_src  = i_start ? i_dividend : r_quo;

    assign w_trial    = {w_rem_src, w_quo_src[DIVIDEND_W-1]};
    assign w_fits     = w_trial >= {1'b0, w_div_src};
    assign w_rem_next = w_fits ? (w_trial[DIVISOR_W-1:0] - w_div_src) : w_trial[DIVISOR_W-1:0];
    assign w_quo_next = {w_quo_src[DIVIDEND_W-2:0], w_fits};

    assign o_busy     = r_busy;
    assign o_done     = w_active && (w_step == STEP_W'(DIVIDEND_W - 1));
    assign o_quotient = w_quo_next[QUOTIENT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_step    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_quo     <= '0;
        end else if (w_active) begin
            r_busy    <= ~o_done;
            r_step    <= w_step + STEP_W'(1);
            r_rem     <= w_rem_next;
            r_divisor <= w_div_src;
            r_quo     <= w_quo_next;
        end
    end

endmodule

// File: rtl/kmeans_centroid_update_k2_d2.sv
// Accumulates points per centroid over an epoch, then divides serially and commits new means.
module kmeans_centroid_update_k2_d2
    import kmeans_centroid_update_k2_d2_pkg::*;
#(
    parameter int unsigned input_data_width = DEF_DATA_W,
    parameter int unsigned count_width      = DEF_COUNT_W,
    parameter logic [input_data_width-1:0] init_c0_d0 = '0,
    parameter logic [input_data_width-1:0] init_c0_d1 = '0,
    parameter logic [input_data_width-1:0] init_c1_d0 = '0,
    parameter logic [input_data_width-1:0] init_c1_d1 = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        input_valid,
    output logic                        input_ready,
    input  logic [input_data_width-1:0] input_data0,
    input  logic [input_data_width-1:0] input_data1,
    input  logic                        selected_centroid,
    input  logic                        input_last,
    output logic [input_data_width-1:0] centroid0_d0,
    output logic [input_data_width-1:0] centroid0_d1,
    output logic [input_data_width-1:0] centroid1_d0,
    output logic [input_data_width-1:0] centroid1_d1,
    output logic                        update_done,
    output logic                        overflow
);

    localparam int unsigned SUM_W = input_data_width + count_width;

    state_t                      r_state, w_state_next;
    logic [SUM_W-1:0]            r_sum_d0 [2];
    logic [SUM_W-1:0]            r_sum_d1 [2];
    logic [count_width-1:0]      r_cnt [2];
    logic [1:0]                  r_div_idx;
    logic [input_data_width-1:0] r_q0, r_q1, r_q2;
    logic [input_data_width-1:0] r_c0_d0, r_c0_d1, r_c1_d0, r_c1_d1;
    logic                        r_overflow;

    logic                        w_hs;
    logic                        w_full;
    logic                        w_div_start;
    logic                        w_div_busy;
    logic                        w_div_done;
    logic [SUM_W-1:0]            w_dividend;
    logic [count_width-1:0]      w_divisor;
    logic [input_data_width-1:0] w_quotient;

    assign w_hs        = input_valid & input_ready;
    assign w_full      = r_cnt[selected_centroid] == '1;
    assign w_div_start = (r_state == DIVIDE) & ~w_div_busy;
    // r_div_idx walks c0d0, c0d1, c1d0, c1d1: bit 1 is the centroid, bit 0 the dimension.
    assign w_dividend  = r_div_idx[0] ? r_sum_d1[r_div_idx[1]] : r_sum_d0[r_div_idx[1]];
    assign w_divisor   = r_cnt[r_div_idx[1]];

    kmeans_serial_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (count_width),
        .QUOTIENT_W (input_data_width)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_dividend),
        .i_divisor  (w_divisor),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quotient)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ACCUM;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        input_ready  = 1'b0;
        update_done  = 1'b0;
        case (r_state)
            ACCUM: begin
                input_ready = 1'b1;
                if (input_valid && input_last) w_state_next = DIVIDE;
            end
            DIVIDE: if (w_div_done && r_div_idx == 2'd3) w_state_next = COMMIT;
            COMMIT: begin
                update_done  = 1'b1;
                w_state_next = ACCUM;
            end
            default: w_state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_d0[0] <= '0;
            r_sum_d0[1] <= '0;
            r_sum_d1[0] <= '0;
            r_sum_d1[1] <= '0;
            r_cnt[0]    <= '0;
            r_cnt[1]    <= '0;
            r_div_idx   <= '0;
            r_q0        <= '0;
            r_q1        <= '0;
            r_q2        <= '0;
            r_overflow  <= 1'b0;
            r_c0_d0     <= init_c0_d0;
            r_c0_d1     <= init_c0_d1;
            r_c1_d0     <= init_c1_d0;
            r_c1_d1     <= init_c1_d1;
        end else begin
            case (r_state)
                ACCUM: if (w_hs) begin
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_sum_d0[selected_centroid] <= r_sum_d0[selected_centroid] + SUM_W'(input_data0);
                        r_sum_d1[selected_centroid] <= r_sum_d1[selected_centroid] + SUM_W'(input_data1);
                        r_cnt[selected_centroid]    <= r_cnt[selected_centroid] + 1'b1;
                    end
                end
                DIVIDE: if (w_div_done) begin
                    r_div_idx <= r_div_idx + 2'd1;
                    case (r_div_idx)
                        2'd0: r_q0 <= w_quotient;
                        2'd1: r_q1 <= w_quotient;
                        2'd2: r_q2 <= w_quotient;
                        default: begin
                            // Last quotient arrives here, so all four centroids land together in the COMMIT cycle.
                            if (r_cnt[0] != '0) begin
                                r_c0_d0 <= r_q0;
                                r_c0_d1 <= r_q1;
                            end
                            if (r_cnt[1] != '0) begin
                                r_c1_d0 <= r_q2;
                                r_c1_d1 <= w_quotient;
                            end
                        end
                    endcase
                end
                COMMIT: begin
                    r_sum_d0[0] <= '0;
                    r_sum_d0[1] <= '0;
                    r_sum_d1[0] <= '0;
                    r_sum_d1[1] <= '0;
                    r_cnt[0]    <= '0;
                    r_cnt[1]    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign centroid0_d0 = r_c0_d0;
    assign centroid0_d1 = r_c0_d1;
    assign centroid1_d0 = r_c1_d0;
    assign centroid1_d1 = r_c1_d1;
    assign overflow     = r_overflow;

endmodule
